// File: rtl/bcd_score_sched.sv
// Score controller: round-robin arbiter over point sources, one shared BCD add per grant, saturating score.
// Latency: ack 3 cycles after the IDLE cycle that samples req; one add per 4 cycles.
// Backpressure: requesters hold req/points until their ack pulse; busy is high outside IDLE.

// Ripple BCD adder, carry out of the top digit is dropped (wrap is detected by the caller).
module bcd_adder #(
  parameter int DIGITS = 4
) (
  input  logic [DIGITS-1:0][3:0] a,
  input  logic [DIGITS-1:0][3:0] b,
  input  logic                   cin,
  output logic [DIGITS-1:0][3:0] sum
);
  logic       carry;
  logic [4:0] t;

  // Per-digit binary add with decimal correction, carry rippling upward.
  always_comb begin
    carry = cin;
    t     = '0;
    sum   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      t = {1'b0, a[i]} + {1'b0, b[i]} + {4'b0, carry};
      if (t > 5'd9) begin
        sum[i] = 4'(t - 5'd10);
        carry  = 1'b1;
      end else begin
        sum[i] = t[3:0];
        carry  = 1'b0;
      end
    end
  end
endmodule

module bcd_score_sched #(
  parameter int DIGITS     = 4,
  parameter int REQ        = 3,
  parameter int LIFE_DIGIT = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [REQ-1:0]                   req,
  input  logic [REQ-1:0][DIGITS-1:0][3:0]  points,
  output logic [REQ-1:0]                   ack,
  input  logic                             clear_score,
  output logic [DIGITS-1:0][3:0]           score,
  output logic [DIGITS-1:0][3:0]           hiscore,
  output logic                             bonus,
  output logic                             busy
);
  localparam int GW = (REQ > 1) ? $clog2(REQ) : 1;

  typedef enum logic [1:0] {IDLE, OPER, COMMIT, ACK} state_t;

  state_t                  state;
  logic [GW-1:0]           rr;
  logic [GW-1:0]           gnt;
  logic [DIGITS-1:0][3:0]  opb;
  logic [DIGITS-1:0][3:0]  add_sum;
  logic [DIGITS-1:0][3:0]  sum_q;
  logic [DIGITS-1:0][3:0]  new_score;
  logic                    wrap;
  logic                    bonus_d;
  logic [GW-1:0]           pick;
  logic [GW-1:0]           idx;
  logic                    found;

  bcd_adder #(.DIGITS(DIGITS)) u_add (
    .a   (score),
    .b   (opb),
    .cin (1'b0),
    .sum (add_sum)
  );

  // Round-robin pick: first asserted request strictly after the last grant, cyclically.
  always_comb begin
    pick  = rr;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= REQ; k++) begin
      idx = GW'((int'(rr) + k) % REQ);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // BCD ordering matches binary ordering, so a smaller sum means the add overflowed.
  always_comb begin
    wrap      = (sum_q < score);
    new_score = wrap ? {DIGITS{4'h9}} : sum_q;
    bonus_d   = (new_score[DIGITS-1:LIFE_DIGIT] != score[DIGITS-1:LIFE_DIGIT]);
  end

  // Transaction sequencer; clear_score overrides any add in flight but still completes the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rr      <= GW'(REQ - 1);
      gnt     <= '0;
      opb     <= '0;
      sum_q   <= '0;
      score   <= '0;
      hiscore <= '0;
      ack     <= '0;
      bonus   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack   <= '0;
      bonus <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_score) begin
            score <= '0;
          end else if (|req) begin
            gnt   <= pick;
            rr    <= pick;
            opb   <= points[pick];
            state <= OPER;
            busy  <= 1'b1;
          end
        end
        OPER: begin
          if (clear_score) begin
            score    <= '0;
            ack[gnt] <= 1'b1;
            state    <= ACK;
          end else begin
            sum_q <= add_sum;
            state <= COMMIT;
          end
        end
        COMMIT: begin
          if (clear_score) begin
            score <= '0;
          end else begin
            score <= new_score;
            bonus <= bonus_d;
            if (new_score > hiscore) hiscore <= new_score;
          end
          ack[gnt] <= 1'b1;
          state    <= ACK;
        end
        ACK: begin
          if (clear_score) score <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_score_sched.sv
// Bench for bcd_score_sched: directed scenarios with literal expectations, then random traffic.
// Expected outputs come from a transaction-level integer model updated on each rising edge.
// Outputs are compared on every falling edge; inputs change only on falling edges.
module tb_bcd_score_sched;
  logic               clk;
  logic               reset;
  logic [2:0]         req;
  logic [2:0][3:0][3:0] points;
  logic [2:0]         ack;
  logic               clear_score;
  logic [3:0][3:0]    score;
  logic [3:0][3:0]    hiscore;
  logic               bonus;
  logic               busy;

  int errors = 0;
  int checks = 0;

  // model state: decimal integers, plus how many edges since the current grant
  int         m_score, m_hi, m_rr, m_g, m_pts, m_age;
  logic [2:0] e_ack;
  logic       e_bonus;

  bcd_score_sched #(.DIGITS(4), .REQ(3), .LIFE_DIGIT(3)) dut (
    .clk(clk), .reset(reset), .req(req), .points(points), .ack(ack),
    .clear_score(clear_score), .score(score), .hiscore(hiscore),
    .bonus(bonus), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int bcd2int(logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] int2bcd(int x);
    logic [15:0] r;
    r[15:12] = 4'((x / 1000) % 10);
    r[11:8]  = 4'((x / 100) % 10);
    r[7:4]   = 4'((x / 10) % 10);
    r[3:0]   = 4'(x % 10);
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    r[3:0]  = 4'($urandom_range(0, 9));
    r[7:4]  = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 3) == 0) begin
      r[11:8]  = 4'($urandom_range(0, 9));
      r[15:12] = 4'($urandom_range(0, 9));
    end else begin
      r[11:8]  = 4'($urandom_range(0, 2));
      r[15:12] = 4'h0;
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour for one rising edge, from the inputs present at that edge.
  task automatic model_update();
    int nv;
    bit got;
    e_ack   = 3'b000;
    e_bonus = 1'b0;
    if (reset) begin
      m_score = 0; m_hi = 0; m_rr = 2; m_g = 0; m_pts = 0; m_age = 0;
      return;
    end
    if (m_age == 0) begin
      if (clear_score) m_score = 0;
      else if (req != 3'b000) begin
        got = 0;
        for (int k = 1; k <= 3; k++) begin
          if (!got && req[(m_rr + k) % 3]) begin
            m_g = (m_rr + k) % 3;
            got = 1;
          end
        end
        m_rr  = m_g;
        m_pts = bcd2int(points[m_g]);
        m_age = 1;
      end
    end else if (m_age == 1 || m_age == 2) begin
      if (clear_score) begin
        m_score = 0;
        e_ack[m_g] = 1'b1;
        m_age = 3;
      end else if (m_age == 1) begin
        m_age = 2;
      end else begin
        nv = m_score + m_pts;
        if (nv > 9999) nv = 9999;
        e_bonus = ((nv / 1000) != (m_score / 1000));
        m_score = nv;
        if (nv > m_hi) m_hi = nv;
        e_ack[m_g] = 1'b1;
        m_age = 3;
      end
    end else begin
      if (clear_score) m_score = 0;
      m_age = 0;
    end
  endtask

  task automatic compare();
    chk("score",   {16'h0, score},   {16'h0, int2bcd(m_score)});
    chk("hiscore", {16'h0, hiscore}, {16'h0, int2bcd(m_hi)});
    chk("ack",     {29'h0, ack},     {29'h0, e_ack});
    chk("bonus",   {31'h0, bonus},   {31'h0, e_bonus});
    chk("busy",    {31'h0, busy},    {31'h0, (m_age != 0)});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; clear_score = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Single-requester add: returns ack latency (0 on timeout) and bonus seen with ack.
  task automatic do_add(int i, logic [15:0] p, output int lat, output logic b);
    lat = 0; b = 1'b0;
    points[i] = p;
    req[i] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (ack[i]) begin
        lat = n; b = bonus;
        break;
      end
    end
    if (lat == 0) chk("add_timeout", 32'd0, 32'd1);
    req[i] = 1'b0;
  endtask

  initial begin
    int lat;
    logic b;
    int nack;
    int ord[3];
    int stamp[3];

    reset = 1'b1; req = '0; clear_score = 1'b0; points = '0;
    m_age = 0; e_ack = '0; e_bonus = 0; m_score = 0; m_hi = 0; m_rr = 2; m_g = 0; m_pts = 0;
    @(negedge clk);
    do_reset();
    chk("rst_score", {16'h0, score}, 32'h0);
    chk("rst_busy",  {31'h0, busy},  32'h0);

    // 0990 then 0020: crosses a thousand, bonus with the ack, 3-cycle latency
    do_add(0, 16'h0990, lat, b);
    chk("t2_pre_score", {16'h0, score}, 32'h0990);
    chk("t2_pre_bonus", {31'h0, b}, 32'h0);
    step();
    do_add(0, 16'h0020, lat, b);
    chk("t2_lat",     lat, 32'd3);
    chk("t2_score",   {16'h0, score},   32'h1010);
    chk("t2_hiscore", {16'h0, hiscore}, 32'h1010);
    chk("t2_bonus",   {31'h0, b}, 32'h1);
    step();

    // clear in IDLE keeps hiscore
    clear_score = 1'b1;
    step();
    clear_score = 1'b0;
    chk("clr_score",   {16'h0, score},   32'h0);
    chk("clr_hiscore", {16'h0, hiscore}, 32'h1010);

    // three simultaneous requests from reset: served 0,1,2 four cycles apart
    do_reset();
    points[0] = 16'h0020; points[1] = 16'h0050; points[2] = 16'h0100;
    req = 3'b111;
    nack = 0;
    for (int c = 1; c <= 20 && nack < 3; c++) begin
      step();
      if (ack != 3'b000) begin
        ord[nack] = ack[0] ? 0 : (ack[1] ? 1 : 2);
        stamp[nack] = c;
        req = req & ~ack;
        nack++;
      end
    end
    chk("t3_nack", nack, 32'd3);
    if (nack == 3) begin
      chk("t3_ord0", ord[0], 32'd0);
      chk("t3_ord1", ord[1], 32'd1);
      chk("t3_ord2", ord[2], 32'd2);
      chk("t3_gap1", stamp[1] - stamp[0], 32'd4);
      chk("t3_gap2", stamp[2] - stamp[1], 32'd4);
    end
    chk("t3_score", {16'h0, score}, 32'h0170);
    req = '0;
    step();

    // saturation: 9950 + 0100 -> 9999 no bonus, then +0001 holds
    do_add(0, 16'h9780, lat, b);
    chk("t4_pre", {16'h0, score}, 32'h9950);
    step();
    do_add(1, 16'h0100, lat, b);
    chk("t4_sat",   {16'h0, score}, 32'h9999);
    chk("t4_bonus", {31'h0, b}, 32'h0);
    step();
    do_add(2, 16'h0001, lat, b);
    chk("t4_hold",   {16'h0, score}, 32'h9999);
    chk("t4_bonus2", {31'h0, b}, 32'h0);
    step();

    // clear during COMMIT: add discarded, ack still pulses, hiscore kept
    do_reset();
    do_add(0, 16'h0500, lat, b);
    step();
    points[0] = 16'h0030; req[0] = 1'b1;
    step();
    step();
    clear_score = 1'b1;
    step();
    clear_score = 1'b0;
    req[0] = 1'b0;
    chk("t5_ack",     {29'h0, ack},     32'h1);
    chk("t5_score",   {16'h0, score},   32'h0);
    chk("t5_hiscore", {16'h0, hiscore}, 32'h0500);
    chk("t5_bonus",   {31'h0, bonus},   32'h0);
    step();

    // add of zero: normal latency, nothing changes
    do_add(1, 16'h0123, lat, b);
    step();
    do_add(2, 16'h0000, lat, b);
    chk("t6_lat",   lat, 32'd3);
    chk("t6_score", {16'h0, score}, 32'h0123);
    chk("t6_bonus", {31'h0, b}, 32'h0);
    step();

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (req[i] && ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          points[i] = rand_bcd();
          req[i] = 1'b1;
        end
      end
      clear_score = ($urandom_range(0, 59) == 0);
      step();
    end
    clear_score = 1'b0;
    req = '0;
    for (int c = 0; c < 6; c++) step();

    // reset arriving mid-OPER clears everything immediately
    do_add(0, 16'h0777, lat, b);
    step();
    points[1] = 16'h0042; req[1] = 1'b1;
    step();
    chk("t1_busy_pre", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    req = '0;
    #1;
    chk("t1_score",   {16'h0, score},   32'h0);
    chk("t1_hiscore", {16'h0, hiscore}, 32'h0);
    chk("t1_ack",     {29'h0, ack},     32'h0);
    chk("t1_busy",    {31'h0, busy},    32'h0);
    chk("t1_bonus",   {31'h0, bonus},   32'h0);
    step();
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
